// File: rtl/clk_divider_n.sv
// Runtime-programmable integer clock divider producing a near-50% o_clk and a rising-edge o_tick.
// Optional runtime ratio load via handshake when CLKDIV_RUNTIME_LOAD_EN is defined.
module clk_divider_n #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic [CNT_W-1:0] div_cur,
    output logic             o_clk,
    output logic             o_tick
);

    localparam int unsigned      DIV_RST_I = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_RST_I);
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(DIV_RST_I - 1);

    // Ratios below 2 cannot form a high and a low phase, so they are raised to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_use;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   half_len;
    logic             wrap;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign half_len = ({1'b0, div_use} + (CNT_W+1)'(1)) >> 1;
    assign wrap     = (cnt_q == (div_use - CNT_W'(1)));

    // Period counter and output waveform
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (ena) begin
            if (wrap) begin
                cnt_d  = '0;
                clk_d  = 1'b1;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
                clk_d = ({1'b0, cnt_inc} < half_len);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_RST;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_tick = tick_q;

`ifdef CLKDIV_RUNTIME_LOAD_EN
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] div_in_cl;

    assign div_in_cl = clamp_div(div_in);

    // New ratio is only adopted on an enabled wrap so the running period is never cut
    always_comb begin
        div_d  = div_q;
        pval_d = pval_q;
        pend_d = pend_q;
        ack_d  = 1'b0;
        if (ena && wrap && (pend_q || div_load)) begin
            div_d  = div_load ? div_in_cl : pval_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end else if (div_load) begin
            pval_d = div_in_cl;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= DIV_RST;
            pval_q <= DIV_RST;
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
        end
    end

    assign div_use = div_q;
    assign div_cur = div_q;
    assign div_ack = ack_q;
`else
    logic load_unused_c;

    assign load_unused_c = ^{div_in, div_load, clamp_div(div_in)};
    assign div_use       = DIV_RST;
    assign div_cur       = DIV_RST;
    assign div_ack       = 1'b0;
`endif

endmodule

// File: tb/tb_clk_divider_n.sv
// Bench for clk_divider_n: per-cycle reference model plus directed scenarios with literal expectations.
module tb_clk_divider_n;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEF_DIV = 2;
`ifdef CLKDIV_RUNTIME_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ena = 1'b1;
    logic [CNT_W-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             div_ack;
    logic [CNT_W-1:0] div_cur;
    logic             o_clk;
    logic             o_tick;

    int n_cmp = 0;
    int n_err = 0;

    clk_divider_n #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk(clk), .rst(rst), .ena(ena), .div_in(div_in), .div_load(div_load),
        .div_ack(div_ack), .div_cur(div_cur), .o_clk(o_clk), .o_tick(o_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampn(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Reference model: position within the period (age) and the ratio governing it
    int   m_n, m_age, m_pval;
    bit   m_pend;
    logic e_clk, e_tick, e_ack;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = clampn(DEF_DIV); m_age = m_n - 1; m_pend = 0; m_pval = 0;
            e_clk = 0; e_tick = 0; e_ack = 0;
        end else begin
            e_ack = 0;
            if (ena && (m_age + 1 == m_n)) begin
                m_age  = 0;
                e_tick = 1;
                if (LOAD_EN && (div_load || m_pend)) begin
                    m_n    = div_load ? clampn(int'(div_in)) : m_pval;
                    m_pend = 0;
                    e_ack  = 1;
                end
            end else begin
                if (ena) m_age++;
                e_tick = 0;
                if (LOAD_EN && div_load) begin
                    m_pval = clampn(int'(div_in));
                    m_pend = 1;
                end
            end
            if (ena) e_clk = (m_age < (m_n + 1) / 2);
        end
        #1;
        chk("model_o_clk",   32'(o_clk),   32'(e_clk));
        chk("model_o_tick",  32'(o_tick),  32'(e_tick));
        chk("model_div_ack", 32'(div_ack), 32'(e_ack));
        chk("model_div_cur", 32'(div_cur), 32'(m_n));
    end

    // Runs until the next o_tick; optional one or two back-to-back load requests starting after edge load_at
    task automatic run_period(input int load_at, input int v1, input int v2, input bit two,
                              output int d, output logic ack);
        d = 0;
        do begin
            if (d == load_at) begin
                @(negedge clk); div_in = CNT_W'(v1); div_load = 1'b1;
            end else if (two && d == load_at + 1) begin
                @(negedge clk); div_in = CNT_W'(v2);
            end else if (load_at >= 0 && d == load_at + 1 + int'(two)) begin
                @(negedge clk); div_load = 1'b0;
            end
            @(posedge clk); #2;
            d++;
        end while (!o_tick && d < 40);
        ack = div_ack;
        if (div_load) begin
            @(negedge clk); div_load = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
        $fatal(1);
    end

    initial begin
        int   d;
        logic a;
        int   highs, ticks;

        // Reset and toggle-divider equivalence
        #1 rst = 1'b1;
        #1;
        chk("rst_o_clk", 32'(o_clk), 32'd0);
        chk("rst_o_tick", 32'(o_tick), 32'd0);
        chk("rst_div_cur", 32'(div_cur), 32'd2);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            chk("n2_o_clk", 32'(o_clk), 32'((i % 2) == 0));
            chk("n2_o_tick", 32'(o_tick), 32'((i % 2) == 0));
        end
        chk("n2_div_cur", 32'(div_cur), 32'd2);

        // Odd ratio 5: 3 high, 2 low
        run_period(0, 5, 0, 1'b0, d, a);
        run_period(0, 5, 0, 1'b0, d, a);
        chk("odd_ack", 32'(a), 32'(LOAD_EN));
        chk("odd_div_cur", 32'(div_cur), LOAD_EN ? 32'd5 : 32'd2);
        highs = int'(o_clk); ticks = int'(o_tick);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #2;
            highs += int'(o_clk); ticks += int'(o_tick);
        end
        chk("odd_highs", 32'(highs), LOAD_EN ? 32'd6 : 32'd5);
        chk("odd_ticks", 32'(ticks), LOAD_EN ? 32'd2 : 32'd5);
        run_period(-1, 0, 0, 1'b0, d, a);

        // Deferred load: N=8, request 4 at cnt=2
        run_period(0, 8, 0, 1'b0, d, a);
        run_period(2, 4, 0, 1'b0, d, a);
        chk("defer_len8", 32'(d), LOAD_EN ? 32'd8 : 32'd2);
        chk("defer_ack", 32'(a), 32'(LOAD_EN));
        run_period(-1, 0, 0, 1'b0, d, a);
        chk("defer_len4", 32'(d), LOAD_EN ? 32'd4 : 32'd2);
        chk("defer_noack", 32'(a), 32'd0);

        // Overwrite 6 with 1 before the wrap; clamps to 2
        run_period(0, 6, 1, 1'b1, d, a);
        chk("ovw_len", 32'(d), LOAD_EN ? 32'd4 : 32'd2);
        chk("ovw_ack", 32'(a), 32'(LOAD_EN));
        run_period(-1, 0, 0, 1'b0, d, a);
        chk("ovw_len2", 32'(d), 32'd2);
        chk("ovw_single_ack", 32'(a), 32'd0);
        chk("ovw_div_cur", 32'(div_cur), 32'd2);

        // Enable freeze at the start of an N=4 high phase, load 3 while frozen
        run_period(0, 4, 0, 1'b0, d, a);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ena = 1'b0;
            if (i == 3) begin div_in = 8'd3; div_load = 1'b1; end
            if (i == 4) div_load = 1'b0;
            @(posedge clk); #2;
            chk("frz_o_clk", 32'(o_clk), 32'd1);
            chk("frz_o_tick", 32'(o_tick), 32'd0);
            chk("frz_ack", 32'(div_ack), 32'd0);
        end
        @(negedge clk); ena = 1'b1; div_load = 1'b0;
        run_period(-1, 0, 0, 1'b0, d, a);
        chk("frz_resume_len", 32'(d), LOAD_EN ? 32'd4 : 32'd2);
        chk("frz_resume_ack", 32'(a), 32'(LOAD_EN));
        run_period(-1, 0, 0, 1'b0, d, a);
        chk("frz_len3", 32'(d), LOAD_EN ? 32'd3 : 32'd2);

        // Asynchronous reset with a request pending
        @(negedge clk); div_in = 8'd7; div_load = 1'b1;
        @(posedge clk);
        @(negedge clk); div_load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_o_clk", 32'(o_clk), 32'd0);
        chk("arst_o_tick", 32'(o_tick), 32'd0);
        chk("arst_ack", 32'(div_ack), 32'd0);
        chk("arst_div_cur", 32'(div_cur), 32'd2);
        @(negedge clk); rst = 1'b0;
        run_period(-1, 0, 0, 1'b0, d, a);
        chk("arst_first_tick", 32'(d), 32'd1);
        chk("arst_noack1", 32'(a), 32'd0);
        run_period(-1, 0, 0, 1'b0, d, a);
        chk("arst_len", 32'(d), 32'd2);
        chk("arst_noack2", 32'(a), 32'd0);
        chk("arst_div_cur_end", 32'(div_cur), 32'd2);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
